// File: rtl/add8_result_acc.sv
// add8_result_acc
// ---------------------------------------------------------------------------
// Accumulates NSAMP results of the registered 8-bit adder ({cout, sum}, a
// 9-bit value 0..511) into an ACC_W-bit total. It then offers the total on a
// valid/ready port and holds it until the consumer takes it.
//
// Optional feature macro: ACC_SATURATE_EN
//   defined   -> on overflow the total clamps at 2^ACC_W-1
//   undefined -> on overflow the total wraps modulo 2^ACC_W
// out_ovf behaves the same way in both builds.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   clr        synchronous clear; drops the partial or held result
//   in_valid   in_sum/in_cout carry an adder result
//   in_sum     adder sum S[7:0]
//   in_cout    adder carry-out
//   in_ready   a sample is accepted this cycle (ACCUM state)
//   out_valid  out_acc holds a completed result (HOLD state)
//   out_ready  consumer takes the result
//   out_acc    accumulated total (shows the partial sum while accumulating)
//   out_count  samples accumulated so far
//   out_ovf    sticky overflow for the current result
//   busy       out_count != 0 or in HOLD
// ---------------------------------------------------------------------------
module add8_result_acc #(
  parameter int ACC_W = 16,
  parameter int NSAMP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in_sum,
  input  logic             in_cout,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_count,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0]       NSAMP_C = 8'(NSAMP);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [7:0]       count_q;
  logic             ovf_q;

  // One extra bit on the adder so the carry out of the accumulator is the
  // overflow flag for this sample.
  logic [ACC_W:0]   sample_w;
  logic [ACC_W:0]   sum_w;
  logic             ovf_w;

  always_comb begin
    sample_w = {{(ACC_W-8){1'b0}}, in_cout, in_sum};
    sum_w    = {1'b0, acc_q} + sample_w;
    ovf_w    = sum_w[ACC_W];
`ifdef ACC_SATURATE_EN
    // Once clamped, any further nonzero sample overflows again and stays
    // clamped, so the total sticks at the maximum.
    acc_d    = ovf_w ? ACC_MAX : sum_w[ACC_W-1:0];
`else
    acc_d    = sum_w[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      // clr wins over any handshake. A sample presented now is dropped.
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q   <= acc_d;
            count_q <= count_q + 8'd1;
            if (ovf_w) begin
              ovf_q <= 1'b1;
            end
            if (count_q == NSAMP_C - 8'd1) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          // Result is frozen. in_valid is ignored because in_ready is low.
          if (out_ready) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  // Every output comes from a register or from the state alone.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    out_acc   = acc_q;
    out_count = count_q;
    out_ovf   = ovf_q;
    busy      = (count_q != 8'd0) || (state_q == HOLD);
  end

endmodule

// File: tb/tb_add8_result_acc.sv
module tb_add8_result_acc;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_cout, out_ready;
  logic [7:0]  in_sum;
  logic        in_ready, out_valid, out_ovf, busy;
  logic [15:0] out_acc;
  logic [7:0]  out_count;

  logic        clr10, v10, c10, ordy10;
  logic [7:0]  s10;
  logic        rdy10, val10, ovf10, busy10;
  logic [9:0]  acc10;
  logic [7:0]  cnt10;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add8_result_acc #(.ACC_W(16), .NSAMP(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_sum(in_sum), .in_cout(in_cout), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf), .busy(busy)
  );

  add8_result_acc #(.ACC_W(10), .NSAMP(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .clr(clr10), .in_valid(v10),
    .in_sum(s10), .in_cout(c10), .in_ready(rdy10),
    .out_valid(val10), .out_ready(ordy10), .out_acc(acc10),
    .out_count(cnt10), .out_ovf(ovf10), .busy(busy10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic vld,
                         input logic [15:0] acc, input logic [7:0] cnt,
                         input logic ovf, input logic bsy);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(rdy));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
    chk({tag, ".out_acc"},   32'(out_acc),   32'(acc));
    chk({tag, ".out_count"}, 32'(out_count), 32'(cnt));
    chk({tag, ".out_ovf"},   32'(out_ovf),   32'(ovf));
    chk({tag, ".busy"},      32'(busy),      32'(bsy));
    $display("[%0t] %s: rdy=%0b vld=%0b acc=%0d cnt=%0d ovf=%0b busy=%0b",
             $time, tag, in_ready, out_valid, out_acc, out_count, out_ovf, busy);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sum = 8'h00; in_cout = 1'b0; out_ready = 1'b0;
    clr10 = 1'b0; v10 = 1'b0; s10 = 8'h00; c10 = 1'b0; ordy10 = 1'b0;

    // Reset state
    tick(); tick();
    chk_all("reset", 1, 0, 0, 0, 0, 0);
    chk("reset10.acc", 32'(acc10), 0);
    rst_n = 1'b1;
    tick();
    chk_all("idle", 1, 0, 0, 0, 0, 0);

    // Basic sum: 4 x 30 with out_ready already high
    out_ready = 1'b1; in_valid = 1'b1; in_sum = 8'h1E; in_cout = 1'b0;
    tick(); chk_all("basic.s1", 1, 0, 30, 1, 0, 1);
    tick(); chk_all("basic.s2", 1, 0, 60, 2, 0, 1);
    tick(); chk_all("basic.s3", 1, 0, 90, 3, 0, 1);
    tick(); chk_all("basic.done", 0, 1, 120, 4, 0, 1);
    in_valid = 1'b0;
    tick(); chk_all("basic.release", 1, 0, 0, 0, 0, 0);

    // Carry included: 4 x 511
    in_valid = 1'b1; in_sum = 8'hFF; in_cout = 1'b1;
    tick(); chk_all("carry.s1", 1, 0, 511, 1, 0, 1);
    tick(); tick(); tick();
    chk_all("carry.done", 0, 1, 2044, 4, 0, 1);
    in_valid = 1'b0;
    tick(); chk_all("carry.release", 1, 0, 0, 0, 0, 0);

    // Overflow on the 10-bit instance: 511, 1022, then overflow at 1533
    v10 = 1'b1; s10 = 8'hFF; c10 = 1'b1; ordy10 = 1'b0;
    tick(); tick();
    chk("ovf.s2.acc", 32'(acc10), 1022);
    chk("ovf.s2.ovf", 32'(ovf10), 0);
    tick();
`ifdef ACC_SATURATE_EN
    chk("ovf.s3.acc", 32'(acc10), 1023);
`else
    chk("ovf.s3.acc", 32'(acc10), 509);
`endif
    chk("ovf.s3.ovf", 32'(ovf10), 1);
    tick();
`ifdef ACC_SATURATE_EN
    chk("ovf.done.acc", 32'(acc10), 1023);
`else
    chk("ovf.done.acc", 32'(acc10), 1020);
`endif
    chk("ovf.done.ovf", 32'(ovf10), 1);
    chk("ovf.done.valid", 32'(val10), 1);
    chk("ovf.done.count", 32'(cnt10), 4);
    $display("[%0t] ovf10: acc=%0d ovf=%0b vld=%0b", $time, acc10, ovf10, val10);
    v10 = 1'b0; ordy10 = 1'b1;
    tick();
    chk("ovf.release.ovf", 32'(ovf10), 0);
    chk("ovf.release.acc", 32'(acc10), 0);
    chk("ovf.release.rdy", 32'(rdy10), 1);

    // Backpressure: value 3, hold 5 cycles with in_valid still high
    out_ready = 1'b0; in_valid = 1'b1; in_sum = 8'h03; in_cout = 1'b0;
    tick(); tick(); tick(); tick();
    chk_all("bp.done", 0, 1, 12, 4, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("bp.hold%0d", i), 0, 1, 12, 4, 0, 1);
    end
    out_ready = 1'b1;
    tick(); chk_all("bp.release", 1, 0, 0, 0, 0, 0);
    out_ready = 1'b0;
    tick(); tick(); tick();
    chk_all("bp.next.s3", 1, 0, 9, 3, 0, 1);
    tick(); chk_all("bp.next.done", 0, 1, 12, 4, 0, 1);
    tick(); chk_all("bp.next.hold", 0, 1, 12, 4, 0, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); chk_all("bp.next.release", 1, 0, 0, 0, 0, 0);

    // Reset mid-accumulation
    out_ready = 1'b0; in_valid = 1'b1; in_sum = 8'h10;
    tick(); tick();
    chk_all("rst.partial", 1, 0, 32, 2, 0, 1);
    rst_n = 1'b0;
    tick(); chk_all("rst.pulse", 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1; in_sum = 8'h01;
    tick(); chk_all("rst.new.s1", 1, 0, 1, 1, 0, 1);
    tick(); tick(); tick();
    chk_all("rst.new.done", 0, 1, 4, 4, 0, 1);

    // clr while holding a result that nobody takes
    clr = 1'b1; in_valid = 1'b1; in_sum = 8'h05;
    tick(); chk_all("clr.hold", 1, 0, 0, 0, 0, 0);
    clr = 1'b0; in_sum = 8'h07;
    tick(); chk_all("clr.after.s1", 1, 0, 7, 1, 0, 1);
    // clr mid-accumulation also drops the sample presented with it
    clr = 1'b1;
    tick(); chk_all("clr.mid", 1, 0, 0, 0, 0, 0);
    clr = 1'b0; in_valid = 1'b0;
    tick(); chk_all("clr.idle", 1, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
